// File: rtl/i2c_reg16_slave.sv
// I2C/SCCB target with a 16-bit register pointer and 8-bit data.
// Transactions: S, dev+W, ptr_hi, ptr_lo, data... , P   (burst write)
//               S, dev+W, ptr_hi, ptr_lo, Sr, dev+R, data..., NACK, P
// Register port handshake: there is no back-pressure. reg_wr_en is a
// single-cycle strobe; reg_wr_addr/reg_wr_data are valid in that cycle and
// hold until the next strobe. reg_rd_addr is the live pointer, and
// reg_rd_data must reflect it by the SCL falling edge that starts a read byte.
module i2c_reg16_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic        reg_wr_en,
  output logic [15:0] reg_wr_addr,
  output logic [7:0]  reg_wr_data,
  output logic [15:0] reg_rd_addr,
  input  logic [7:0]  reg_rd_data,
  output logic        busy,
  output logic [3:0]  state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV, S_DEV_ACK, S_AH, S_AH_ACK, S_AL, S_AL_ACK,
    S_WDAT, S_WDAT_ACK, S_RDAT, S_RDAT_ACK, S_IGNORE
  } state_t;

  state_t      state, state_next;
  logic        scl_s1, scl_s2, scl_d;
  logic        sda_s1, sda_s2, sda_d;
  logic [3:0]  bit_cnt, bit_cnt_next;
  logic [7:0]  shreg, shreg_next;
  logic [15:0] pointer, pointer_next;
  logic        sda_oe_next, busy_next, wr_en_next;
  logic [15:0] wr_addr_next;
  logic [7:0]  wr_data_next;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]  byte_in;

  assign reg_rd_addr = pointer;
  assign state_dbg   = state;

  // Two-stage synchronizers plus one delay stage for edge detection; reset
  // to the idle-bus level so releasing reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {scl_s1, scl_s2, scl_d} <= 3'b111;
      {sda_s1, sda_s2, sda_d} <= 3'b111;
    end else begin
      {scl_s1, scl_s2, scl_d} <= {scl_in, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_d} <= {sda_in, sda_s1, sda_s2};
    end
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  // SCL must be steadily high across the SDA change so a late SCL edge is
  // never mistaken for a bus condition.
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
  assign byte_in   = {shreg[6:0], sda_s2};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state and datapath decisions; bus conditions outrank SCL edges.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shreg_next   = shreg;
    pointer_next = pointer;
    sda_oe_next  = sda_oe;
    busy_next    = busy;
    wr_en_next   = 1'b0;
    wr_addr_next = reg_wr_addr;
    wr_data_next = reg_wr_data;
    if (start_det) begin
      state_next   = S_DEV;
      bit_cnt_next = 4'd0;
      sda_oe_next  = 1'b0;
    end else if (stop_det) begin
      state_next   = S_IDLE;
      bit_cnt_next = 4'd0;
      sda_oe_next  = 1'b0;
      busy_next    = 1'b0;
    end else begin
      case (state)
        S_DEV, S_AH, S_AL, S_WDAT: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            shreg_next   = byte_in;
            bit_cnt_next = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              case (state)
                S_DEV: begin
                  if (byte_in[7:1] == DEV_ADDR) begin
                    busy_next = 1'b1;
                  end else begin
                    state_next = S_IGNORE;
                    busy_next  = 1'b0;
                  end
                end
                S_AH: pointer_next[15:8] = byte_in;
                S_AL: pointer_next[7:0]  = byte_in;
                default: begin
                  wr_en_next   = 1'b1;
                  wr_addr_next = pointer;
                  wr_data_next = byte_in;
                  pointer_next = pointer + 16'd1;
                end
              endcase
            end
          end else if (scl_fall && bit_cnt == 4'd8) begin
            sda_oe_next = 1'b1;
            case (state)
              S_DEV:   state_next = S_DEV_ACK;
              S_AH:    state_next = S_AH_ACK;
              S_AL:    state_next = S_AL_ACK;
              default: state_next = S_WDAT_ACK;
            endcase
          end
        end
        S_DEV_ACK: begin
          if (scl_fall) begin
            bit_cnt_next = 4'd0;
            if (shreg[0]) begin
              state_next  = S_RDAT;
              shreg_next  = reg_rd_data;
              sda_oe_next = ~reg_rd_data[7];
            end else begin
              state_next  = S_AH;
              sda_oe_next = 1'b0;
            end
          end
        end
        S_AH_ACK, S_AL_ACK, S_WDAT_ACK: begin
          if (scl_fall) begin
            bit_cnt_next = 4'd0;
            sda_oe_next  = 1'b0;
            case (state)
              S_AH_ACK: state_next = S_AL;
              default:  state_next = S_WDAT;
            endcase
          end
        end
        S_RDAT: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            bit_cnt_next = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            sda_oe_next = 1'b0;
            state_next  = S_RDAT_ACK;
          end else if (scl_fall && bit_cnt != 4'd0) begin
            shreg_next  = {shreg[6:0], 1'b0};
            sda_oe_next = ~shreg[6];
          end
        end
        S_RDAT_ACK: begin
          if (scl_rise) begin
            pointer_next = pointer + 16'd1;
            if (sda_s2) state_next = S_IGNORE;
          end else if (scl_fall) begin
            state_next   = S_RDAT;
            bit_cnt_next = 4'd0;
            shreg_next   = reg_rd_data;
            sda_oe_next  = ~reg_rd_data[7];
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers; reset releases SDA immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= 4'd0;
      shreg       <= 8'd0;
      pointer     <= 16'd0;
      sda_oe      <= 1'b0;
      busy        <= 1'b0;
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= 16'd0;
      reg_wr_data <= 8'd0;
    end else begin
      bit_cnt     <= bit_cnt_next;
      shreg       <= shreg_next;
      pointer     <= pointer_next;
      sda_oe      <= sda_oe_next;
      busy        <= busy_next;
      reg_wr_en   <= wr_en_next;
      reg_wr_addr <= wr_addr_next;
      reg_wr_data <= wr_data_next;
    end
  end

endmodule

// File: doc/i2c_reg16_slave.md
# i2c_reg16_slave

Synthesizable I2C/SCCB responder with 16-bit register sub-address and 8-bit data, the target-side counterpart of the CMOS sensor configuration path (one 24-bit {addr16,data8} write per transaction). Used as a sensor register-model stand-in in simulation benches and as a debug register port on the FPGA. It oversamples SCL/SDA on the system clock, decodes START/STOP, ACKs its device address and exposes register writes/reads on a simple parallel strobe interface.

## Interface
- DEV_ADDR, 7'h30, 7-bit device address responded to
- clk  input  1  system clock; must be ≥ 10× SCL frequency
- rst_n  input  1  asynchronous, active-low reset
- scl_in  input  1  SCL pad input (asynchronous)
- sda_in  input  1  SDA pad input (asynchronous)
- sda_oe  output  1  1 = drive SDA low (open-drain); 0 = release
- reg_wr_en  output  1  one-cycle write strobe
- reg_wr_addr  output  16  write address, valid with reg_wr_en
- reg_wr_data  output  8  write data, valid with reg_wr_en
- reg_rd_addr  output  16  current register pointer (read address)
- reg_rd_data  input  8  register content at reg_rd_addr, combinational or stable ≥1 clk
- busy  output  1  high from accepted device address until STOP/abort

## Operation
- Input sync: 2-FF synchronizer on scl_in/sda_in, plus one delay stage for edge detection. scl_rise/scl_fall from synced SCL; START = synced SDA 1→0 while SCL high; STOP = SDA 0→1 while SCL high.
- Bit counter 0..8 per byte; data bits MSB first, sampled on scl_rise; slave drives/releases SDA only on scl_fall.
- States: IDLE, DEV, DEV_ACK, AH, AH_ACK, AL, AL_ACK, WDAT, WDAT_ACK, RDAT, RDAT_ACK, IGNORE.
- START (incl. repeated START) from any state → DEV, bit counter cleared, sda_oe=0. STOP from any state → IDLE, sda_oe=0, busy=0.
- DEV: 8 bits shifted. Bits[7:1]==DEV_ADDR → DEV_ACK (drive ACK low during 9th clock); R/W=0 → AH next, R/W=1 → RDAT next. Mismatch → IGNORE (no ACK) until START/STOP.
- AH/AL: load pointer[15:8] then pointer[7:0], each ACKed. After AL_ACK → WDAT.
- WDAT: on 8th bit sampled, reg_wr_en pulses with reg_wr_addr=pointer, reg_wr_data=byte; ACK; pointer += 1 (16-bit, FFFF→0000). Further bytes → consecutive addresses.
- Transaction with only sub-address then Sr+read: pointer set, no write pulse (random read).
- RDAT: on scl_fall closing DEV_ACK/RDAT_ACK, latch reg_rd_data into shift register; drive sda_oe = ~bit. After 8 bits release SDA, sample master ACK on 9th scl_rise: ACK(0) → pointer += 1, next byte; NACK(1) → pointer += 1, IGNORE.
- Write pulse only on complete byte; STOP/START mid-byte discards partial byte.

## Timing
- Reset: sda_oe=0, reg_wr_en=0, reg_wr_addr=0, reg_wr_data=0, reg_rd_addr=0, busy=0, state IDLE.
- Pad-to-decision latency: 3 clk (2 sync + 1 edge).
- reg_wr_en asserted exactly 1 clk, 1 clk after the scl_rise sampling the 8th data bit.
- ACK: sda_oe set 1 clk after scl_fall ending bit 8, cleared 1 clk after the scl_fall ending bit 9.
- reg_rd_data sampled 1 clk after the relevant scl_fall; reg_rd_addr updates 1 clk after master-ACK sample.
- START and STOP are mutually exclusive per cycle; START/STOP outrank scl edges in the same cycle.
- Reset mid-transaction: immediate return to reset values; SDA released asynchronously.

## Test plan
- Write 0x30<<1|0, 0x3E, 0x01, 0x45, STOP → 3 ACKs + data ACK; single reg_wr_en with addr 16'h3E01, data 8'h45.
- Burst write to 16'h36E9: 0x80, 0x24, 0x14 → three pulses at 16'h36E9/36EA/36EB, pointer ends 16'h36EC.
- Random read 16'h3107 (model returns 8'hA5), Sr, read, master NACK → SDA bits 1010_0101, no write pulse.
- Device address 7'h31 → no ACK on any byte, no strobes, busy stays 0.
- Burst write at 16'hFFFF, 2 bytes → pulses at 16'hFFFF then 16'h0000.
- STOP after 4 bits of data byte, then rst_n low mid-address phase → no reg_wr_en, all outputs at reset values, sda_oe=0.
